braun_mac_accumulator: RTL and testbench

Downstream consumer of the 2-bit Braun multiplier. It accepts operand pairs over a valid/ready handshake and registers each 4-bit product. It sums a frame of COUNT products and presents the frame total on a second valid/ready handshake. The block turns the combinational multiplier into a pipelined dot-product stage for the datapath that follows it.

---
 rtl/braun_pkg.sv | 18 +
 rtl/braun_multiplier.sv | 26 ++
 rtl/braun_mac_accumulator.sv | 101 ++++++++++
 tb/tb_braun_mac_accumulator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/braun_pkg.sv
// rtl/braun_pkg.sv - shared types and sizing helpers for the Braun multiplier datapath
package braun_pkg;

  // Operand width of the Braun multiplier (unsigned).
  localparam int OP_W = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } braun_mac_state_t;

  // A 4-bit product is at most 9, so 4 + clog2(count) bits hold count*9.
  function automatic int acc_width(input int count);
    return 4 + $clog2(count);
  endfunction

endpackage

// File: rtl/braun_multiplier.sv
// rtl/braun_multiplier.sv - 2x2 unsigned Braun array multiplier, purely combinational
module braun_multiplier
  import braun_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [2*OP_W-1:0] p
);

  logic pp00, pp01, pp10, pp11;
  logic c1;

  // Partial products of the array.
  assign pp00 = a[0] & b[0];
  assign pp10 = a[1] & b[0];
  assign pp01 = a[0] & b[1];
  assign pp11 = a[1] & b[1];

  // Half-adder row: bit 1 and its carry, then bit 2 and the carry into bit 3.
  assign c1   = pp10 & pp01;
  assign p[0] = pp00;
  assign p[1] = pp10 ^ pp01;
  assign p[2] = pp11 ^ c1;
  assign p[3] = pp11 & c1;

endmodule

// File: rtl/braun_mac_accumulator.sv
// rtl/braun_mac_accumulator.sv - frame accumulator of registered Braun products with valid/ready in and out
module braun_mac_accumulator
  import braun_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OP_W-1:0]               a,
  input  logic [OP_W-1:0]               b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [acc_width(COUNT)-1:0]   out_sum
);

  localparam int ACC_W = acc_width(COUNT);
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  braun_mac_state_t  state;
  logic [3:0]        mult_p;
  logic [3:0]        prod_q;
  logic              prod_v;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  sum_cnt;
  logic              accept;

  braun_multiplier u_mult (
    .a (a),
    .b (b),
    .p (mult_p)
  );

  // Ready is a decode of the registered state; held low while reset is asserted.
  assign in_ready = ~rst & (state == COLLECT);
  assign accept   = in_valid & in_ready;

  // Product stage: capture a*b on each accept; prod_v marks a product awaiting its add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      prod_v <= 1'b0;
    end else begin
      prod_v <= accept;
      if (accept) begin
        prod_q <= mult_p;
      end
    end
  end

  // Frame FSM with the accumulate stage; the last add and the DONE entry share one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      acc       <= '0;
      acc_cnt   <= '0;
      sum_cnt   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      if (prod_v) begin
        acc     <= acc + ACC_W'(prod_q);
        sum_cnt <= sum_cnt + CNT_W'(1);
      end
      case (state)
        COLLECT: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == LAST) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (prod_v && (sum_cnt == LAST)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_sum   <= acc + ACC_W'(prod_q);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            out_sum   <= '0;
            acc       <= '0;
            acc_cnt   <= '0;
            sum_cnt   <= '0;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_braun_mac_accumulator.sv
// tb/tb_braun_mac_accumulator.sv - directed self-checking bench for braun_mac_accumulator
module tb_braun_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] a = 2'd0;
  logic [1:0] b = 2'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [5:0] out_sum;

  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [1:0] a2 = 2'd0;
  logic [1:0] b2 = 2'd0;
  logic       out_valid2;
  logic       out_ready2 = 1'b1;
  logic [4:0] out_sum2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  braun_mac_accumulator #(.COUNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  braun_mac_accumulator #(.COUNT(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_sum   (out_sum2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for in_ready, presents one pair for one edge.
  task automatic send(input logic [1:0] x, input logic [1:0] y);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", in_ready, 1);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 1'b0;
    a = 2'd3;
    b = 2'd3;
  endtask

  // Four pairs with 'gap' idle cycles between them; checks drain/valid timing and the sum.
  task automatic frame(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input int gap, input int exp);
    for (int i = 0; i < 4; i++) begin
      send(av[2*i +: 2], bv[2*i +: 2]);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          a = 2'(g + 1);
          b = 2'd3;
          @(negedge clk);
        end
      end
    end
    check({tag, "_in_ready_drop"}, in_ready, 0);
    check({tag, "_valid_early"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, out_sum, exp);
    check({tag, "_in_ready_done"}, in_ready, 0);
  endtask

  // Called one negedge after DONE was entered with out_ready high.
  task automatic after_handshake(input string tag);
    @(negedge clk);
    check({tag, "_valid_clr"}, out_valid, 0);
    check({tag, "_sum_clr"}, out_sum, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    @(negedge clk);

    // Max values: 4 x (3,3) = 36.
    out_ready = 1'b1;
    frame("max", 8'b11_11_11_11, 8'b11_11_11_11, 0, 36);
    after_handshake("max");

    // Mixed operands with gaps: (1,2),(2,1),(0,3),(3,2) -> 2+2+0+6 = 10.
    frame("gaps", {2'd3, 2'd0, 2'd2, 2'd1}, {2'd2, 2'd3, 2'd1, 2'd2}, 2, 10);
    after_handshake("gaps");

    // Backpressure: 4 x (2,2) = 16 held for 5 cycles, then 4 x (1,1) = 4.
    out_ready = 1'b0;
    frame("bp", {4{2'd2}}, {4{2'd2}}, 0, 16);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", out_sum, 16);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    after_handshake("bp");
    frame("bp_next", {4{2'd1}}, {4{2'd1}}, 0, 4);
    after_handshake("bp_next");

    // Reset mid-frame after 2 of 4 accepts.
    send(2'd2, 2'd3);
    send(2'd2, 2'd3);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sum", out_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame("after_rst", {4{2'd2}}, {4{2'd3}}, 0, 24);
    after_handshake("after_rst");

    // Zero frame: (0,3),(0,1),(0,2),(0,0).
    frame("zero", 8'b00_00_00_00, {2'd0, 2'd2, 2'd1, 2'd3}, 1, 0);
    after_handshake("zero");

    // Exhaustive products on COUNT = 2: frame (x,y),(0,0) sums to x*y.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        check("ex_in_ready", in_ready2, 1);
        in_valid2 = 1'b1;
        a2 = 2'(x);
        b2 = 2'(y);
        @(negedge clk);
        a2 = 2'd0;
        b2 = 2'd0;
        @(negedge clk);
        in_valid2 = 1'b0;
        a2 = 2'd3;
        b2 = 2'd3;
        check("ex_in_ready_drop", in_ready2, 0);
        @(negedge clk);
        check("ex_valid", out_valid2, 1);
        check("ex_sum", out_sum2, x * y);
        @(negedge clk);
        check("ex_valid_clr", out_valid2, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
